uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter. It accepts bytes from an on-chip master over a req/ack handshake and stores them in a small FIFO. It serializes them LSB-first onto a single TX line for the host's receiver. It is the device-to-host direction of the board serial link, instantiated inside the SoC next to the UART receive path and driving the board UART_RXD_OUT pin.

Parameters:
BAUD_DIV, 868, clock cycles per bit; 868 gives 115200 baud at 100 MHz; legal range 2..65535
FIFO_DEPTH, 8, byte entries in the FIFO; power of two, 2..64
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
tx_req_i  input  1  master requests to enqueue tx_data_bi
tx_data_bi  input  8  byte to transmit
tx_ack_o  output  1  byte accepted this cycle
tx_o  output  1  serial line, idle high
busy_o  output  1  FIFO non-empty or shifter active
fifo_full_o  output  1  FIFO holds FIFO_DEPTH entries
fifo_cnt_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock (clk_i); rst_i is synchronous and active-high.
- Reset values:
  - tx_o=1, tx_ack_o=0, busy_o=0, fifo_full_o=0, fifo_cnt_o=0.
  - FSM=IDLE, baud counter=0, FIFO pointers=0.
- Enqueue handshake:
  - tx_ack_o is combinational: tx_ack_o = tx_req_i & !fifo_full_o.
  - On an acked cycle the byte is written at the rising edge.
  - The master may hold tx_req_i; one byte is accepted per acked cycle.
  - A request while full is stalled (no ack), never dropped.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Count updates by +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
  - Write while full is impossible because ack=0.
  - Simultaneous write+pop while full: ack=0, so only the pop occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If the FIFO is non-empty, pop the head into shift register sh[7:0], clear bit index, load baud counter, go to START. The pop and the START entry happen on the same edge. Latency from an ack on an empty idle FIFO to the tx_o falling edge is 2 cycles.
  - START: tx_o=0 for BAUD_DIV cycles, then DATA.
  - DATA: tx_o=sh[0] for BAUD_DIV cycles per bit; shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx_o=1 for STOP_BITS*BAUD_DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter:
  - 16-bit down-counter loaded with BAUD_DIV-1 at each bit start.
  - Bit boundary when the counter is 0.
  - Every bit lasts exactly BAUD_DIV cycles, no drift.
- tx_o is driven from a register (glitch-free pin output).
- busy_o = (FSM!=IDLE) | (fifo_cnt_o!=0), registered-equivalent timing.
- Reset mid-frame: on the next edge tx_o=1 and the FIFO is flushed. The truncated frame is seen by the receiver as a framing error; this is acceptable.
- Writes during transmission are accepted normally; the FIFO decouples the master from the line.

Test Plan:
- Reset, then single byte 0x55, BAUD_DIV=4:
  - tx_o low at cycle 2 after ack.
  - Line pattern 0,1,0,1,0,1,0,1,0,1, each level 4 cycles, then idle high.
  - busy_o falls exactly 40 cycles after the start bit begins.
- Back-to-back bytes 0xA3, 0x0F:
  - Second start bit immediately follows the first stop bit (no gap).
  - Decoded bytes are 0xA3 then 0x0F.
- Fill FIFO_DEPTH=8 plus extra:
  - Hold tx_req_i with 10 bytes while the line is slow (BAUD_DIV=16).
  - 9 acks occur rapidly (8 stored plus 1 popped into the shifter); fifo_full_o=1; the 10th is stalled until the next pop.
  - All 10 bytes arrive in order.
- Simultaneous write and pop at cnt=3: fifo_cnt_o stays 3 and the data order is preserved.
- STOP_BITS=2: stop interval is 2*BAUD_DIV cycles high before the next start bit.
- Assert rst_i during DATA bit 4: tx_o=1 next cycle, fifo_cnt_o=0, busy_o=0, and there is no further line activity.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: req/ack byte intake into a circular FIFO,
// LSB-first serialisation onto a registered, idle-high TX line.
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tx_req_i,
  input  logic [7:0]                    tx_data_bi,
  output logic                          tx_ack_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [15:0]     BaudLoad = 16'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] DepthVal = CntW'(FIFO_DEPTH);
  localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  state_e          state_q;
  logic [15:0]     baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      sh_q;
  logic            tx_q;

  logic            fifo_empty, push, pop, stop_done;

  assign fifo_empty  = (cnt_q == '0);
  assign fifo_full_o = (cnt_q == DepthVal);
  assign tx_ack_o    = tx_req_i & ~fifo_full_o;
  assign push        = tx_ack_o;

  // Last stop bit ends this cycle: a pending byte goes straight into START.
  assign stop_done = (state_q == StStop) && (baud_q == '0) && (bit_idx_q == StopLast);
  assign pop       = ~fifo_empty & ((state_q == StIdle) | stop_done);

  assign tx_o       = tx_q;
  assign fifo_cnt_o = cnt_q;
  assign busy_o     = (state_q != StIdle) | ~fifo_empty;

  // FIFO storage; contents need no reset since occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data_bi;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Serialiser FSM with baud down-counter and registered line output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            sh_q      <= mem_q[rd_ptr_q];
            bit_idx_q <= '0;
            baud_q    <= BaudLoad;
            tx_q      <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (baud_q == '0) begin
            baud_q  <= BaudLoad;
            tx_q    <= sh_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        StData: begin
          if (baud_q == '0) begin
            baud_q <= BaudLoad;
            sh_q   <= {1'b0, sh_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= sh_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        StStop: begin
          if (baud_q == '0) begin
            if (bit_idx_q == StopLast) begin
              if (pop) begin
                sh_q      <= mem_q[rd_ptr_q];
                bit_idx_q <= '0;
                baud_q    <= BaudLoad;
                tx_q      <= 1'b0;
                state_q   <= StStart;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              baud_q    <= BaudLoad;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: instance A (4 clk/bit, 1 stop) and instance B (16 clk/bit, 2 stop),
// each with a line decoder checking received bytes against an expected-byte queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int unsigned BaudA = 4;
  localparam int unsigned BaudB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, req_a, ack_a, tx_a, busy_a, full_a;
  logic [7:0] data_a;
  logic [3:0] cnt_a;
  logic       rst_b, req_b, ack_b, tx_b, busy_b, full_b;
  logic [7:0] data_b;
  logic [3:0] cnt_b;

  uart_tx_fifo #(.BAUD_DIV(BaudA), .FIFO_DEPTH(8), .STOP_BITS(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .tx_req_i(req_a), .tx_data_bi(data_a), .tx_ack_o(ack_a),
    .tx_o(tx_a), .busy_o(busy_a), .fifo_full_o(full_a), .fifo_cnt_o(cnt_a)
  );

  uart_tx_fifo #(.BAUD_DIV(BaudB), .FIFO_DEPTH(8), .STOP_BITS(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .tx_req_i(req_b), .tx_data_bi(data_b), .tx_ack_o(ack_b),
    .tx_o(tx_b), .busy_o(busy_b), .fifo_full_o(full_b), .fifo_cnt_o(cnt_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  int unsigned start_a[$];
  int unsigned start_b[$];
  bit          abort_a = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line decoder A: mid-bit sampling from the first low cycle of the start bit.
  initial begin : mon_a
    logic [7:0] b;
    logic       s0, p;
    forever begin
      @(negedge clk);
      if (rst_a === 1'b0 && tx_a === 1'b0) begin
        start_a.push_back(cyc);
        repeat (BaudA / 2) @(negedge clk);
        s0 = tx_a;
        for (int i = 0; i < 8; i++) begin
          repeat (BaudA) @(negedge clk);
          b[i] = tx_a;
        end
        repeat (BaudA) @(negedge clk);
        p = tx_a;
        if (!abort_a) begin
          check("a_start_mid", s0, 0);
          check("a_stop", p, 1);
          check("a_frame_expected", exp_a.size() != 0, 1);
          if (exp_a.size() != 0) check("a_byte", b, exp_a.pop_front());
        end
      end
    end
  end

  // Line decoder B: same idea, two stop bits.
  initial begin : mon_b
    logic [7:0] b;
    logic       s0, p0, p1;
    forever begin
      @(negedge clk);
      if (rst_b === 1'b0 && tx_b === 1'b0) begin
        start_b.push_back(cyc);
        repeat (BaudB / 2) @(negedge clk);
        s0 = tx_b;
        for (int i = 0; i < 8; i++) begin
          repeat (BaudB) @(negedge clk);
          b[i] = tx_b;
        end
        repeat (BaudB) @(negedge clk);
        p0 = tx_b;
        repeat (BaudB) @(negedge clk);
        p1 = tx_b;
        check("b_start_mid", s0, 0);
        check("b_stop1", p0, 1);
        check("b_stop2", p1, 1);
        check("b_frame_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) check("b_byte", b, exp_b.pop_front());
      end
    end
  end

  task automatic wait_idle_a(input int limit);
    int n = 0;
    while ((busy_a || exp_a.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("a_drain", n < limit, 1);
  endtask

  task automatic wait_idle_b(input int limit);
    int n = 0;
    while ((busy_b || exp_b.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("b_drain", n < limit, 1);
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] frame;  // line level per bit time, bit 0 = start bit
  } vec_t;

  vec_t        vecs[5];
  logic [7:0]  fill[10];
  int unsigned ack_cyc[10];

  initial begin
    vecs[0] = '{data: 8'h55, frame: 10'h2AA};
    vecs[1] = '{data: 8'hA3, frame: 10'h346};
    vecs[2] = '{data: 8'h00, frame: 10'h200};
    vecs[3] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[4] = '{data: 8'h0F, frame: 10'h21E};
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    for (int i = 0; i < 10; i++) ack_cyc[i] = 0;

    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    data_a = '0;  data_b = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_full_a", full_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_ack_a", ack_a, 0);
    check("rst_tx_b", tx_b, 1);
    check("rst_cnt_b", cnt_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // Single bytes on an idle line: exact waveform, latency and busy timing.
    for (int v = 0; v < 5; v++) begin
      data_a = vecs[v].data;
      req_a  = 1'b1;
      #1;
      check("vec_ack", ack_a, 1);
      exp_a.push_back(vecs[v].data);
      @(negedge clk);
      req_a = 1'b0;
      check("vec_tx_before_start", tx_a, 1);
      @(negedge clk);
      for (int k = 0; k < 40; k++) begin
        check("vec_line", tx_a, vecs[v].frame[k / 4]);
        check("vec_busy", busy_a, 1);
        @(negedge clk);
      end
      check("vec_busy_fall", busy_a, 0);
      check("vec_tx_idle", tx_a, 1);
    end
    wait_idle_a(200);

    // Back-to-back bytes: second start bit directly after the first stop bit.
    start_a.delete();
    data_a = 8'hA3; req_a = 1'b1;
    #1; check("b2b_ack0", ack_a, 1); exp_a.push_back(8'hA3);
    @(negedge clk);
    data_a = 8'h0F;
    #1; check("b2b_ack1", ack_a, 1); exp_a.push_back(8'h0F);
    @(negedge clk);
    req_a = 1'b0;
    wait_idle_a(300);
    check("b2b_frames", start_a.size(), 2);
    if (start_a.size() >= 2) check("b2b_gap", start_a[1] - start_a[0], 40);

    // Write coinciding with a pop at occupancy 3 leaves the count unchanged.
    for (int i = 0; i < 4; i++) begin
      data_a = 8'h31 + 8'(i); req_a = 1'b1;
      #1; check("wp_ack", ack_a, 1); exp_a.push_back(8'h31 + 8'(i));
      @(negedge clk);
    end
    req_a = 1'b0;
    check("wp_cnt_before", cnt_a, 3);
    repeat (37) @(negedge clk);
    check("wp_cnt_at_pop", cnt_a, 3);
    data_a = 8'h35; req_a = 1'b1;
    #1; check("wp_ack5", ack_a, 1); exp_a.push_back(8'h35);
    @(negedge clk);
    req_a = 1'b0;
    check("wp_cnt_after", cnt_a, 3);
    wait_idle_a(400);

    // Fill B past capacity with req held; then check gapless 2-stop-bit stream.
    begin
      int idx = 0;
      int n = 0;
      bit full_seen = 1'b0;
      start_b.delete();
      while (idx < 10 && n < 400) begin
        data_b = fill[idx]; req_b = 1'b1;
        #1;
        if (ack_b) begin
          ack_cyc[idx] = cyc;
          exp_b.push_back(fill[idx]);
          idx++;
        end
        @(negedge clk);
        n++;
        if (idx == 9 && !full_seen) begin
          full_seen = 1'b1;
          check("fill_full", full_b, 1);
          check("fill_cnt8", cnt_b, 8);
          check("fill_stall_ack", ack_b, 0);
        end
      end
      req_b = 1'b0;
      check("fill_all_acked", idx, 10);
      check("fill_9th_ack", ack_cyc[8] - ack_cyc[0], 8);
      check("fill_10th_ack", ack_cyc[9] - ack_cyc[0], 178);
    end
    wait_idle_b(3000);
    check("fill_frames", start_b.size(), 10);
    begin
      int bad = 0;
      for (int i = 1; i < start_b.size(); i++) begin
        if (start_b[i] - start_b[i-1] != 176) bad++;
      end
      check("fill_gapless_2stop", bad, 0);
    end

    // Reset during data bit 4 of A with further bytes queued.
    abort_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_a = (i == 0) ? 8'h00 : 8'h66; req_a = 1'b1;
      #1; check("rst_mid_ack", ack_a, 1);
      @(negedge clk);
    end
    req_a = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_bit4_low", tx_a, 0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    exp_a.delete();
    check("rst_mid_tx", tx_a, 1);
    check("rst_mid_cnt", cnt_a, 0);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_full", full_a, 0);
    begin
      int lows = 0;
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
      end
      check("rst_mid_quiet", lows, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
